// File: rtl/ctrl_fsm_mc.sv
// Multi-cycle fetch/decode/execute controller for the simple RISC datapath.
// The HALT instruction (opcode 111) is built only when CTRL_HALT_EN is defined; otherwise 111 is a NOP.
module ctrl_fsm_mc #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_opcode,
  input  logic [1:0] i_op,
  output logic       o_loada,
  output logic       o_loadb,
  output logic       o_loadc,
  output logic       o_loads,
  output logic       o_asel,
  output logic       o_bsel,
  output logic       o_write,
  output logic [1:0] o_vsel,
  output logic [2:0] o_nsel,
  output logic       o_load_pc,
  output logic       o_reset_pc,
  output logic       o_load_ir,
  output logic       o_load_addr,
  output logic       o_addr_sel,
  output logic [1:0] o_mem_cmd,
  output logic       o_halted
);

  localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] IF_WAIT_LD = (MEM_LAT > 0) ? CW'(MEM_LAT - 1) : '0;
  // Memory access states include their command cycle, so they wait MEM_LAT more.
  localparam logic [CW-1:0] MEM_WAIT_LD = CW'(MEM_LAT);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF_WAIT, S_IF2, S_UPD_PC, S_DECODE,
    S_WR_IMM, S_GET_A, S_GET_B, S_ALU_B, S_ALU_AB, S_WR_RD, S_CMP_S,
    S_ADDR, S_LD_ADDR, S_MEM_RD, S_WR_MEM, S_GET_RD, S_MEM_WR
`ifdef CTRL_HALT_EN
    , S_HALT
`endif
  } state_t;

  typedef struct packed {
    logic [1:0] mem_cmd;
    logic       addr_sel;
    logic       load_addr;
    logic       load_ir;
    logic       reset_pc;
    logic       load_pc;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       bsel;
    logic       asel;
    logic       loads;
    logic       loadc;
    logic       loadb;
    logic       loada;
  } outs_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  outs_t         r_out;
  logic [4:0]    w_ins;

  assign w_ins = {i_opcode, i_op};

  function automatic outs_t decode_out(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      S_RST:     begin o.reset_pc = 1'b1; o.load_pc = 1'b1; end
      S_IF1,
      S_IF_WAIT: begin o.addr_sel = 1'b1; o.mem_cmd = 2'b01; end
      S_IF2:     begin o.addr_sel = 1'b1; o.mem_cmd = 2'b01; o.load_ir = 1'b1; end
      S_UPD_PC:  o.load_pc = 1'b1;
      S_WR_IMM:  begin o.nsel = 3'b001; o.vsel = 2'b10; o.write = 1'b1; end
      S_GET_A:   begin o.nsel = 3'b001; o.loada = 1'b1; end
      S_GET_B:   begin o.nsel = 3'b100; o.loadb = 1'b1; end
      S_ALU_B:   begin o.asel = 1'b1; o.loadc = 1'b1; end
      S_ALU_AB:  o.loadc = 1'b1;
      S_WR_RD:   begin o.nsel = 3'b010; o.vsel = 2'b00; o.write = 1'b1; end
      S_CMP_S:   o.loads = 1'b1;
      S_ADDR:    begin o.bsel = 1'b1; o.loadc = 1'b1; end
      S_LD_ADDR: o.load_addr = 1'b1;
      S_MEM_RD:  o.mem_cmd = 2'b01;
      S_WR_MEM:  begin o.mem_cmd = 2'b01; o.nsel = 3'b010; o.vsel = 2'b11; o.write = 1'b1; end
      S_GET_RD:  begin o.nsel = 3'b010; o.loadb = 1'b1; end
      S_MEM_WR:  o.mem_cmd = 2'b10;
      default:   o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    w_state_nxt = S_IF1;
    case (r_state)
      S_RST:     w_state_nxt = S_IF1;
      S_IF1:     w_state_nxt = (MEM_LAT == 0) ? S_IF2 : S_IF_WAIT;
      S_IF_WAIT: w_state_nxt = (r_cnt == '0) ? S_IF2 : S_IF_WAIT;
      S_IF2:     w_state_nxt = S_UPD_PC;
      S_UPD_PC:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        casez (w_ins)
          5'b11010:         w_state_nxt = S_WR_IMM;
          5'b11000, 5'b10111: w_state_nxt = S_GET_B;
          5'b10100, 5'b10110,
          5'b10101, 5'b01100,
          5'b10000:         w_state_nxt = S_GET_A;
`ifdef CTRL_HALT_EN
          5'b111??:         w_state_nxt = S_HALT;
`endif
          default:          w_state_nxt = S_IF1;
        endcase
      end
      S_GET_A: begin
        case (i_opcode)
          3'b101:         w_state_nxt = S_GET_B;
          3'b011, 3'b100: w_state_nxt = S_ADDR;
          default:        w_state_nxt = S_IF1;
        endcase
      end
      S_GET_B: begin
        case (w_ins)
          5'b11000, 5'b10111: w_state_nxt = S_ALU_B;
          5'b10100, 5'b10110: w_state_nxt = S_ALU_AB;
          5'b10101:           w_state_nxt = S_CMP_S;
          default:            w_state_nxt = S_IF1;
        endcase
      end
      S_ALU_B:   w_state_nxt = (i_opcode == 3'b100) ? S_MEM_WR : S_WR_RD;
      S_ALU_AB:  w_state_nxt = S_WR_RD;
      S_ADDR:    w_state_nxt = S_LD_ADDR;
      S_LD_ADDR: w_state_nxt = (i_opcode == 3'b100) ? S_GET_RD : S_MEM_RD;
      S_MEM_RD:  w_state_nxt = (r_cnt == '0) ? S_WR_MEM : S_MEM_RD;
      S_GET_RD:  w_state_nxt = S_ALU_B;
      S_MEM_WR:  w_state_nxt = (r_cnt == '0) ? S_IF1 : S_MEM_WR;
`ifdef CTRL_HALT_EN
      S_HALT:    w_state_nxt = S_HALT;
`endif
      default:   w_state_nxt = S_IF1;
    endcase
  end

  // Outputs are registered from the next state, so they always match the Moore decode of r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RST;
      r_cnt   <= '0;
      r_out   <= decode_out(S_RST);
    end else begin
      r_state <= w_state_nxt;
      r_out   <= decode_out(w_state_nxt);
      if (w_state_nxt == S_IF_WAIT && r_state != S_IF_WAIT)
        r_cnt <= IF_WAIT_LD;
      else if ((w_state_nxt == S_MEM_RD && r_state != S_MEM_RD) ||
               (w_state_nxt == S_MEM_WR && r_state != S_MEM_WR))
        r_cnt <= MEM_WAIT_LD;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

`ifdef CTRL_HALT_EN
  logic r_halted;
  always_ff @(posedge clk) begin
    if (rst) r_halted <= 1'b0;
    else     r_halted <= (w_state_nxt == S_HALT);
  end
  assign o_halted = r_halted;
`else
  assign o_halted = 1'b0;
`endif

  assign o_loada     = r_out.loada;
  assign o_loadb     = r_out.loadb;
  assign o_loadc     = r_out.loadc;
  assign o_loads     = r_out.loads;
  assign o_asel      = r_out.asel;
  assign o_bsel      = r_out.bsel;
  assign o_write     = r_out.write;
  assign o_vsel      = r_out.vsel;
  assign o_nsel      = r_out.nsel;
  assign o_load_pc   = r_out.load_pc;
  assign o_reset_pc  = r_out.reset_pc;
  assign o_load_ir   = r_out.load_ir;
  assign o_load_addr = r_out.load_addr;
  assign o_addr_sel  = r_out.addr_sel;
  assign o_mem_cmd   = r_out.mem_cmd;

endmodule
